// File: rtl/riscv_pkg.sv
// Shared EduRISC-V definitions: datapath widths and the fetch-stage entry type.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int ILEN        = 32;
    localparam int FETCH_DEPTH = 2;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO of fetch entries with a synchronous flush.
// Used both as the decode-facing instruction buffer and as the tag queue
// that remembers which PC each outstanding memory request belongs to.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;
    logic         do_push;

    // A pop on an empty FIFO is ignored; a push into a full FIFO is only
    // honoured when the head leaves in the same cycle.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = entries[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // Payload storage needs no reset because occupancy gates its visibility.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            entries[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to instruction
// memory under a two-slot credit, tags responses with their PC and hands
// {instr, pc} to decode. A redirect reloads the PC, flushes both queues and
// arranges for responses to requests still in flight to be thrown away.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] next_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [ILEN-1:0] id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] pc_plus4_o
);

    logic [XLEN-1:0] pc;
    logic [1:0]      outstanding;
    logic [1:0]      drop_cnt;
    logic [2:0]      credit_used;
    logic            req_fire;
    logic            rsp_keep;

    fetch_entry_t    buf_din;
    fetch_entry_t    buf_dout;
    logic [1:0]      buf_count;
    logic            buf_pop;

    fetch_entry_t    pcq_din;
    fetch_entry_t    pcq_dout;
    logic [1:0]      pcq_count;
    logic            unused_pcq;

    // Every slot is spoken for by a request in flight, a buffered
    // instruction, or a stale response still to be swallowed.
    assign credit_used      = {1'b0, outstanding} + {1'b0, buf_count} + {1'b0, drop_cnt};
    assign imem_req_valid_o = !redirect_i && (credit_used < 3'(FETCH_DEPTH));
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign imem_addr_o      = pc;
    assign pc_plus4_o       = pc + XLEN'(4);

    // A response is kept only when it is not owed to an earlier redirect
    // and no redirect is happening right now.
    assign rsp_keep = imem_rsp_valid_i && (drop_cnt == 2'd0) && !redirect_i;

    assign pcq_din.instr = '0;
    assign pcq_din.pc    = pc;
    assign buf_din.instr = imem_rsp_data_i;
    assign buf_din.pc    = pcq_dout.pc;
    assign buf_pop       = id_valid_o && id_ready_i;

    assign id_valid_o = (buf_count != 2'd0);
    assign id_instr_o = buf_dout.instr;
    assign id_pc_o    = buf_dout.pc;

    // The PC queue never carries instruction bits and its depth is implied
    // by the outstanding count, so those outputs are deliberately ignored.
    assign unused_pcq = ^{pcq_dout.instr, pcq_count};

    fetch_fifo u_pc_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_i),
        .push  (req_fire),
        .pop   (rsp_keep),
        .din   (pcq_din),
        .dout  (pcq_dout),
        .count (pcq_count)
    );

    fetch_fifo u_resp_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_i),
        .push  (rsp_keep),
        .pop   (buf_pop),
        .din   (buf_din),
        .dout  (buf_dout),
        .count (buf_count)
    );

    // PC register: redirect wins, otherwise advance on each accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_i) begin
            pc <= next_pc_i;
        end else if (req_fire) begin
            pc <= pc + XLEN'(4);
        end
    end

    // In-flight and to-be-dropped counts; on redirect every request not
    // answered this cycle becomes a response to discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
        end else if (redirect_i) begin
            outstanding <= outstanding - 2'(imem_rsp_valid_i);
            drop_cnt    <= outstanding - 2'(imem_rsp_valid_i);
        end else begin
            outstanding <= outstanding + 2'(req_fire) - 2'(imem_rsp_valid_i);
            if (imem_rsp_valid_i && (drop_cnt != 2'd0)) begin
                drop_cnt <= drop_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable instruction memory
// model answering each request with the bitwise inverse of its address, and
// a decode monitor recording every delivered {pc, instr}.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] next_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic [31:0] pc_plus4_o;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } del_t;

    req_t mem_q[$];
    del_t got[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   mem_lat = 1;
    int   max_inflight = 0;

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_i       (redirect_i),
        .next_pc_i        (next_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_instr_o       (id_instr_o),
        .id_pc_o          (id_pc_o),
        .pc_plus4_o       (pc_plus4_o)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory response driver: answers in order once a request's latency expires.
    initial begin
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n === 1'b1 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = ~mem_q[0].addr;
                mem_q.delete(0);
            end else begin
                imem_rsp_valid_i = 1'b0;
                imem_rsp_data_i  = '0;
            end
        end
    end

    // Mid-cycle observer: accepted requests, decode pops, in-flight high-water mark.
    initial begin
        req_t r;
        del_t d;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (imem_req_valid_o && imem_req_ready_i) begin
                    r.addr = imem_addr_o;
                    r.due  = cyc + mem_lat;
                    mem_q.push_back(r);
                end
                if (id_valid_o && id_ready_i) begin
                    d.pc    = id_pc_o;
                    d.instr = id_instr_o;
                    got.push_back(d);
                end
                if (mem_q.size() + int'(imem_rsp_valid_i) > max_inflight) begin
                    max_inflight = mem_q.size() + int'(imem_rsp_valid_i);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n            = 1'b0;
        redirect_i       = 1'b0;
        next_pc_i        = '0;
        id_ready_i       = 1'b1;
        imem_req_ready_i = 1'b1;
        mem_q.delete();
        got.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_q.delete();
        got.delete();
    endtask

    task automatic wait_got(input int n, output bit ok);
        for (int i = 0; i < 80; i++) begin
            if (got.size() >= n) break;
            step();
        end
        ok = (got.size() >= n);
    endtask

    task automatic test_reset();
        rst_n            = 1'b1;
        redirect_i       = 1'b0;
        next_pc_i        = '0;
        id_ready_i       = 1'b1;
        imem_req_ready_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_addr_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_addr: got %h, expected %h", imem_addr_o, 32'h0);
        end
        checks++;
        if (pc_plus4_o !== 32'h4) begin
            fails++;
            $display("[TB] FAIL reset_plus4: got %h, expected %h", pc_plus4_o, 32'h4);
        end
        checks++;
        if (id_valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_id_valid: got %b, expected 0", id_valid_o);
        end
        checks++;
        if (imem_req_valid_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_req_valid: got %b, expected 1", imem_req_valid_o);
        end
    endtask

    task automatic test_stream();
        bit ok;
        mem_lat = 1;
        do_reset();
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h0 || imem_req_valid_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stream_first_req: got addr %h valid %b, expected 00000000 1",
                     imem_addr_o, imem_req_valid_o);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL stream_latency: got valid %b pc %h, expected 1 00000000",
                     id_valid_o, id_pc_o);
        end
        checks++;
        if (id_instr_o !== 32'hFFFF_FFFF) begin
            fails++;
            $display("[TB] FAIL stream_first_instr: got %h, expected ffffffff", id_instr_o);
        end
        step();
        wait_got(8, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL stream_timeout: got %0d deliveries, expected 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                logic [31:0] exp_pc;
                exp_pc = 32'(4 * i);
                checks++;
                if (got[i].pc !== exp_pc || got[i].instr !== ~exp_pc) begin
                    fails++;
                    $display("[TB] FAIL stream_seq[%0d]: got pc %h instr %h, expected %h %h",
                             i, got[i].pc, got[i].instr, exp_pc, ~exp_pc);
                end
            end
        end
    endtask

    task automatic test_decode_stall();
        int          n0;
        logic [31:0] frozen;
        logic [31:0] head;
        bit          ok;
        id_ready_i = 1'b0;
        n0   = got.size();
        head = 32'(4 * n0);
        repeat (3) @(negedge clk);
        frozen = imem_addr_o;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req_valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_req_valid: got %b, expected 0", imem_req_valid_o);
        end
        checks++;
        if (imem_addr_o !== frozen) begin
            fails++;
            $display("[TB] FAIL stall_pc_frozen: got %h, expected %h", imem_addr_o, frozen);
        end
        step();
        id_ready_i = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== head) begin
            fails++;
            $display("[TB] FAIL stall_buf0: got valid %b pc %h, expected 1 %h", id_valid_o, id_pc_o, head);
        end
        @(negedge clk);
        checks++;
        if (id_valid_o !== 1'b1 || id_pc_o !== head + 32'd4) begin
            fails++;
            $display("[TB] FAIL stall_buf1: got valid %b pc %h, expected 1 %h",
                     id_valid_o, id_pc_o, head + 32'd4);
        end
        @(negedge clk);
        checks++;
        if (id_valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stall_only_two: got valid %b, expected 0", id_valid_o);
        end
        step();
        wait_got(n0 + 6, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL stall_timeout: got %0d deliveries, expected %0d", got.size(), n0 + 6);
        end else begin
            for (int i = 0; i < n0 + 6; i++) begin
                checks++;
                if (got[i].pc !== 32'(4 * i)) begin
                    fails++;
                    $display("[TB] FAIL stall_order[%0d]: got %h, expected %h", i, got[i].pc, 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect();
        bit saw_valid;
        bit ok;
        mem_lat = 3;
        do_reset();
        step();
        step();
        redirect_i = 1'b1;
        next_pc_i  = 32'h100;
        @(negedge clk);
        checks++;
        if (imem_req_valid_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL redir_req_valid: got %b, expected 0", imem_req_valid_o);
        end
        step();
        redirect_i = 1'b0;
        got.delete();
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h100) begin
            fails++;
            $display("[TB] FAIL redir_addr: got %h, expected 00000100", imem_addr_o);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (id_valid_o !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) begin
            fails++;
            $display("[TB] FAIL redir_gap: got id_valid high, expected low until target response");
        end
        wait_got(2, ok);
        checks++;
        if (!ok || got[0].pc !== 32'h100 || got[0].instr !== 32'hFFFF_FEFF) begin
            fails++;
            $display("[TB] FAIL redir_first: got %0d entries pc %h, expected pc 00000100 instr fffffeff",
                     got.size(), ok ? got[0].pc : 32'hx);
        end
        checks++;
        if (!ok || got[1].pc !== 32'h104) begin
            fails++;
            $display("[TB] FAIL redir_second: got pc %h, expected 00000104", ok ? got[1].pc : 32'hx);
        end
    endtask

    task automatic test_redirect_with_rsp();
        bit found;
        bit ok;
        mem_lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (imem_rsp_valid_i && id_valid_o) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            fails++;
            $display("[TB] FAIL rsp_redir_setup: got no cycle with response and valid, expected one");
        end
        redirect_i = 1'b1;
        next_pc_i  = 32'h200;
        step();
        redirect_i = 1'b0;
        got.delete();
        wait_got(2, ok);
        checks++;
        if (!ok || got[0].pc !== 32'h200 || got[0].instr !== 32'hFFFF_FDFF) begin
            fails++;
            $display("[TB] FAIL rsp_redir_first: got pc %h, expected 00000200", ok ? got[0].pc : 32'hx);
        end
        checks++;
        if (!ok || got[1].pc !== 32'h204) begin
            fails++;
            $display("[TB] FAIL rsp_redir_second: got pc %h, expected 00000204", ok ? got[1].pc : 32'hx);
        end
    endtask

    task automatic test_mem_stall();
        bit hold_ok;
        bit ok;
        mem_lat = 3;
        do_reset();
        imem_req_ready_i = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (imem_addr_o !== 32'h0 || imem_req_valid_o !== 1'b1) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            fails++;
            $display("[TB] FAIL memstall_hold: got addr %h valid %b, expected 00000000 1",
                     imem_addr_o, imem_req_valid_o);
        end
        step();
        imem_req_ready_i = 1'b1;
        max_inflight = 0;
        repeat (15) step();
        checks++;
        if (max_inflight != 2) begin
            fails++;
            $display("[TB] FAIL memstall_inflight: got %0d, expected 2", max_inflight);
        end
        wait_got(3, ok);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!ok || got[i].pc !== 32'(4 * i)) begin
                fails++;
                $display("[TB] FAIL memstall_seq[%0d]: got %0d entries, expected pc %h", i, got.size(), 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        bit ok;
        mem_lat = 1;
        do_reset();
        repeat (4) step();
        redirect_i = 1'b1;
        next_pc_i  = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        got.delete();
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL wrap_top: got addr %h plus4 %h, expected fffffffc 00000000",
                     imem_addr_o, pc_plus4_o);
        end
        checks++;
        if (imem_req_valid_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wrap_penalty: got req_valid %b, expected 1", imem_req_valid_o);
        end
        @(negedge clk);
        checks++;
        if (imem_addr_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL wrap_next: got %h, expected 00000000", imem_addr_o);
        end
        step();
        wait_got(2, ok);
        checks++;
        if (!ok || got[0].pc !== 32'hFFFF_FFFC || got[1].pc !== 32'h0) begin
            fails++;
            $display("[TB] FAIL wrap_deliver: got %0d entries, expected pcs fffffffc 00000000", got.size());
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_addr_o !== 32'h0 || pc_plus4_o !== 32'h4) begin
            fails++;
            $display("[TB] FAIL midreset_pc: got addr %h plus4 %h, expected 00000000 00000004",
                     imem_addr_o, pc_plus4_o);
        end
        checks++;
        if (id_valid_o !== 1'b0 || imem_req_valid_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midreset_valids: got id_valid %b req_valid %b, expected 0 1",
                     id_valid_o, imem_req_valid_o);
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_stream();
        test_decode_stall();
        test_redirect();
        test_redirect_with_rsp();
        test_mem_stall();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
